inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_pkg.sv | 59 +++++
 rtl/inst_loader_if.sv | 21 ++
 rtl/inst_fifo.sv | 66 ++++++
 rtl/inst_loader.sv | 123 ++++++++++++
 tb/tb_inst_loader.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_pkg.sv
// Shared constants, state type and instruction encoder for the instruction loader.
package inst_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_LDI = 8'h07;
    localparam logic [7:0] OP_CMP = 8'h08;

    localparam int OP_LSB  = 24;
    localparam int W_LSB   = 16;
    localparam int IMM_LSB = 8;
    localparam int R1_LSB  = 8;
    localparam int R2_LSB  = 0;

    localparam int WORD_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int PROG_DEPTH = 32;
    localparam int ADDR_W     = 5;
    localparam int CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic is_legal(input logic [7:0] op);
        return (op == OP_NOP) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_LDI) || (op == OP_CMP);
    endfunction

    // Unrecognised opcodes fall through to {op, 24'h0}; NOP naturally yields zero.
    function automatic logic [WORD_W-1:0] encode(
        input logic [7:0] op,
        input logic [3:0] w_add,
        input logic [7:0] imm,
        input logic [3:0] r1,
        input logic [3:0] r2
    );
        logic [WORD_W-1:0] word;
        word = '0;
        word[OP_LSB +: 8] = op;
        case (op)
            OP_ADD, OP_SUB, OP_CMP: begin
                word[R1_LSB +: 4] = r1;
                word[R2_LSB +: 4] = r2;
            end
            OP_LDI: begin
                word[W_LSB +: 4]   = w_add;
                word[IMM_LSB +: 8] = imm;
            end
            default: ;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Instruction field stream between a producer and the loader.
interface inst_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_op;
    logic [3:0] in_w_add;
    logic [7:0] in_data;
    logic [3:0] in_r1;
    logic [3:0] in_r2;
    logic       in_last;

    modport master (
        output in_valid, in_op, in_w_add, in_data, in_r1, in_r2, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_w_add, in_data, in_r1, in_r2, in_last,
        output in_ready
    );
endinterface

// File: rtl/inst_fifo.sv
// Small synchronous FIFO with full/empty flags, flush and show-ahead read port.
module inst_fifo
    import inst_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg;
    logic [PTR_W:0]   rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;
    logic [DEPTH-1:0] entry_we;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
    assign push_ok  = push && !full && !flush;
    assign pop_ok   = pop && !empty && !flush;
    assign pop_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = push_ok && (wr_ptr_reg[PTR_W-1:0] == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: encodes field-level instructions into 32-bit words and writes
// them to program memory. Optional macro INST_ILLEGAL_CHECK_EN drops illegal opcodes.
module inst_loader
    import inst_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_loader_if.slave      bus,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
`ifdef INST_ILLEGAL_CHECK_EN
    output logic              err_illegal,
`endif
    output logic [CNT_W-1:0]  count
);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   accepted_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [WORD_W-1:0]  mem_wdata_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               start_ok;
    logic               fire;
    logic               push;
    logic               pop;
    logic [WORD_W-1:0]  word;
    logic [WORD_W-1:0]  fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    assign start_ok    = (state_reg == ST_IDLE) && start;
    assign bus.in_ready = (state_reg == ST_LOAD) && !fifo_full &&
                          (accepted_reg < CNT_W'(PROG_DEPTH));
    assign fire        = bus.in_valid && bus.in_ready;
    assign word        = encode(bus.in_op, bus.in_w_add, bus.in_data, bus.in_r1, bus.in_r2);
    assign pop         = ((state_reg == ST_LOAD) || (state_reg == ST_DRAIN)) && !fifo_empty;

`ifdef INST_ILLEGAL_CHECK_EN
    logic legal;
    logic err_illegal_reg;

    assign legal       = is_legal(bus.in_op);
    assign push        = fire && legal;
    assign err_illegal = err_illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_illegal_reg <= 1'b0;
        else        err_illegal_reg <= fire && !legal;
    end
`else
    assign push = fire;
`endif

    inst_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start_ok),
        .push      (push),
        .push_data (word),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD:  if (fire && (bus.in_last || accepted_reg == CNT_W'(PROG_DEPTH - 1)))
                          state_next = ST_DRAIN;
            // A write still on the bus has not yet been counted, so wait for it.
            ST_DRAIN: if (fifo_empty && !mem_we_reg) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            accepted_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            count_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            mem_we_reg <= pop;
            if (pop) mem_wdata_reg <= fifo_rdata;
            if (start_ok) begin
                mem_addr_reg <= base_addr;
                count_reg    <= '0;
                accepted_reg <= '0;
            end else begin
                // Address and count advance once the write has been presented.
                if (mem_we_reg) begin
                    mem_addr_reg <= mem_addr_reg + 1'b1;
                    count_reg    <= count_reg + 1'b1;
                end
                if (fire) accepted_reg <= accepted_reg + 1'b1;
            end
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign count     = count_reg;
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
    assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: stimulus pushes expected writes, a monitor checks them.
module tb_inst_loader;
    import inst_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [5:0]  count;
`ifdef INST_ILLEGAL_CHECK_EN
    logic        err_illegal;
`endif

    inst_loader_if bus();

    inst_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
`ifdef INST_ILLEGAL_CHECK_EN
        .err_illegal(err_illegal),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   writes_seen = 0;
    int   err_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mem_we) begin
            writes_seen++;
            $display("write addr=%0d data=%08h", mem_addr, mem_wdata);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %08h expected no write", mem_addr, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
`ifdef INST_ILLEGAL_CHECK_EN
        if (rst_n && err_illegal) begin
            err_pulses++;
            $display("err_illegal pulse");
        end
`endif
    end

    task automatic start_session(input logic [4:0] base);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the edge that transferred.
    task automatic send(input logic [7:0] op, input logic [3:0] w, input logic [7:0] d,
                        input logic [3:0] r1, input logic [3:0] r2, input logic last,
                        input logic exp_write, input logic [4:0] addr, input logic [31:0] exp_word);
        logic rdy;
        int   n;
        bus.in_op = op; bus.in_w_add = w; bus.in_data = d;
        bus.in_r1 = r1; bus.in_r2 = r2; bus.in_last = last;
        bus.in_valid = 1'b1;
        if (exp_write) sb_q.push_back('{addr: addr, data: exp_word});
        n = 0;
        rdy = 1'b0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
    endtask

    task automatic wait_done(input logic [5:0] exp_count, input string tag);
        logic seen;
        int   n;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        $display("%s done count=%0d", tag, count);
        if (seen) begin
            check({tag, "_count"}, 32'(count), 32'(exp_count));
            check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, 32'(done), 32'd0);
        end
    endtask

    task automatic set_add(input int idx);
        bus.in_op = OP_ADD;
        bus.in_w_add = 4'h0;
        bus.in_data = 8'h00;
        bus.in_r1 = 4'(idx % 16);
        bus.in_r2 = 4'(15 - (idx % 16));
        bus.in_last = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, late, cycles, post, w0;
        logic rdy;
        logic [3:0] r1, r2;

        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_w_add = '0; bus.in_data = '0;
        bus.in_r1 = '0; bus.in_r2 = '0; bus.in_last = 1'b0;

        #7;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD r2,r1 as the only instruction
        start_session(5'd0);
        check("t1_busy", 32'(busy), 32'd1);
        send(OP_ADD, 4'h0, 8'h00, 4'h2, 4'h1, 1'b1, 1'b1, 5'd0, 32'h01000201);
        wait_done(6'd1, "t1");

        // LDI, SUB, CMP from base 5
        start_session(5'd5);
        send(OP_LDI, 4'h5, 8'h0A, 4'h0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h07050A00);
        send(OP_SUB, 4'h0, 8'h00, 4'h0, 4'h7, 1'b0, 1'b1, 5'd6, 32'h02000007);
        send(OP_CMP, 4'h0, 8'h00, 4'h9, 4'h0, 1'b1, 1'b1, 5'd7, 32'h08000900);
        wait_done(6'd3, "t2");

        // address wrap 30, 31, 0
        start_session(5'd30);
        send(OP_NOP, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 5'd30, 32'h00000000);
        send(OP_NOP, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 1'b1, 5'd31, 32'h00000000);
        send(OP_NOP, 4'h0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b1, 5'd0, 32'h00000000);
        wait_done(6'd3, "t3");

        // valid held high for 33 words; only 32 may be accepted
        w0 = writes_seen;
        start_session(5'd0);
        acc = 0; late = 0; cycles = 0; post = 0;
        set_add(0);
        r1 = 4'd0; r2 = 4'd15;
        sb_q.push_back('{addr: 5'd0, data: {8'h01, 12'h000, r1, 4'h0, r2}});
        bus.in_valid = 1'b1;
        while (cycles < 80 && post < 2) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk); #1;
            cycles++;
            if (acc >= 32) post++;
            if (rdy) begin
                if (acc >= 32) late++;
                else begin
                    acc++;
                    set_add(acc);
                    if (acc < 32) begin
                        r1 = 4'(acc % 16);
                        r2 = 4'(15 - (acc % 16));
                        sb_q.push_back('{addr: 5'(acc), data: {8'h01, 12'h000, r1, 4'h0, r2}});
                    end
                end
            end
        end
        bus.in_valid = 1'b0;
        check("t4_accepted", 32'(acc), 32'd32);
        check("t4_ready_after_32", 32'(late), 32'd0);
        wait_done(6'd32, "t4");
        check("t4_write_total", 32'(writes_seen - w0), 32'd32);

        // reset with words in flight
        start_session(5'd10);
        send(OP_ADD, 4'h0, 8'h00, 4'h3, 4'h4, 1'b0, 1'b1, 5'd10, 32'h01000304);
        send(OP_SUB, 4'h0, 8'h00, 4'h5, 4'h6, 1'b0, 1'b1, 5'd11, 32'h02000506);
        send(OP_LDI, 4'hC, 8'h99, 4'h0, 4'h0, 1'b0, 1'b1, 5'd12, 32'h070C9900);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        sb_q.delete();
        w0 = writes_seen;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_writes", 32'(writes_seen - w0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);

        // opcode 55h
        start_session(5'd3);
`ifdef INST_ILLEGAL_CHECK_EN
        w0 = err_pulses;
        send(8'h55, 4'hF, 8'hFF, 4'hF, 4'hF, 1'b1, 1'b0, 5'd3, 32'h00000000);
        wait_done(6'd0, "t6");
        check("t6_err_pulses", 32'(err_pulses - w0), 32'd1);
`else
        send(8'h55, 4'hF, 8'hFF, 4'hF, 4'hF, 1'b1, 1'b1, 5'd3, 32'h55000000);
        wait_done(6'd1, "t6");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
